ctrl_merge: RTL and testbench
=============================

// Module: ctrl_merge
// PURPOSE
//  Read-side counterpart of the MMI control write splitter. Collects byte responses
//  returned by the MMI peripheral into a small FIFO and serves them to the CPU load
//  path as memory-mapped registers (RX_DATA, STATUS), with sticky error and threshold irq.
//  Sits between the peripheral response bus and the core data-memory read mux.
// PARAMETERS
//  DEPTH     8          FIFO entries; power of two, 2..128
//  IRQ_TH    4          irq asserts when count >= IRQ_TH; 0 disables irq
//  ADDR_DATA 32'h18     RX_DATA register address
//  ADDR_STAT 32'h19     STATUS register address
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  p_valid    in   1   peripheral byte strobe (fire-and-forget, no backpressure)
//  p_data     in   8   peripheral response byte
//  valid      in   1   CPU read request
//  ren        in   4   CPU byte-lane read enables
//  addr       in   32  CPU read address
//  o_data     out  32  read data, registered
//  o_valid    out  1   read data valid, one-cycle pulse
//  irq        out  1   level interrupt, count >= IRQ_TH
// BEHAVIOUR
//  Reset: FIFO empty (rd/wr ptr 0, count 0), overflow 0, o_data 0, o_valid 0, irq 0.
//  Push: p_valid & (count<DEPTH | pop this cycle) -> p_data written at wr_ptr, wr_ptr++.
//  Full, p_valid, no pop -> byte dropped, overflow sticky set, pointers unchanged.
//  Pop: valid & addr==ADDR_DATA & ren!=0 & count!=0 -> rd_ptr++.
//  Push+pop same cycle: both happen, count unchanged; when full, push is accepted.
//  Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1, never exceeds DEPTH.
//  Read latency 1: request in cycle N -> o_valid=1 and o_data in cycle N+1.
//  RX_DATA: head byte in lane of lowest set ren bit (ren[0]->[7:0] .. ren[3]->[31:24]),
//   other lanes 0. Empty FIFO or ren==0: o_data=0, o_valid pulses, no state change.
//  STATUS: [7:0] count (zero-extended), [8] empty, [9] full, [10] overflow, [11] irq,
//   [31:12] 0; ren ignored. Read clears overflow after sampling; a new overflow
//   event in the same cycle leaves it set.
//  Other addresses or valid=0: o_valid=0, o_data=0 next cycle; no state change.
//  Back-to-back reads each cycle supported; each RX_DATA read pops exactly one byte.
//  irq = (IRQ_TH!=0) & (count>=IRQ_TH), derived from registered count.
//  rst asserted mid-operation: all state cleared immediately; FIFO contents discarded.
// TESTING
//  Push 0xA1,0xB2,0xC3; read 0x18 ren=0001 x3 -> o_data 0xA1,0xB2,0xC3 in order, 1-cycle lat.
//  Push 9 bytes (DEPTH=8), read 0x19 -> count 8, full 1, overflow 1; re-read -> overflow 0.
//  Full FIFO, push 0x5A and pop same cycle -> no overflow, count 8, 0x5A read last.
//  Read 0x18 ren=0100 with head 0x3C -> o_data 0x003C0000; empty read -> 0x0, o_valid 1.
//  IRQ_TH=4: push 3 -> irq 0; push 4th -> irq 1; pop one -> irq 0.
//  Push 5, assert rst mid-stream -> count 0, empty 1, irq 0, o_valid 0 immediately.

Source files
------------

// File: rtl/ctrl_merge.sv
// rtl/ctrl_merge.sv - peripheral response byte FIFO served to the CPU load path as RX_DATA/STATUS registers
module ctrl_merge #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned IRQ_TH    = 4,
  parameter logic [31:0] ADDR_DATA = 32'h18,
  parameter logic [31:0] ADDR_STAT = 32'h19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_valid,
  input  logic [7:0]  p_data,
  input  logic        valid,
  input  logic [3:0]  ren,
  input  logic [31:0] addr,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   o_data_q, o_data_d;
  logic          o_valid_q, o_valid_d;

  logic          empty, full, irq_w;
  logic          data_rd, stat_rd, pop, push, ovf_evt;
  logic [7:0]    head;
  logic [31:0]   lane_word;
  logic [31:0]   status_word;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign irq_w   = (IRQ_TH != 0) && (32'(count_q) >= IRQ_TH);
  assign head    = mem_q[rd_ptr_q];

  assign data_rd = valid && (addr == ADDR_DATA);
  assign stat_rd = valid && (addr == ADDR_STAT);
  assign pop     = data_rd && (ren != 4'b0000) && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts the byte.
  assign push    = p_valid && (!full || pop);
  assign ovf_evt = p_valid && !push;

  // Head byte lands in the lane of the lowest enabled byte.
  always_comb begin
    lane_word = 32'h0;
    if (ren[0])      lane_word[7:0]   = head;
    else if (ren[1]) lane_word[15:8]  = head;
    else if (ren[2]) lane_word[23:16] = head;
    else if (ren[3]) lane_word[31:24] = head;
  end

  assign status_word = {20'h0, irq_w, ovf_q, full, empty, 8'(count_q)};

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = p_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // STATUS read clears overflow after it was sampled; a fresh drop in the same cycle wins.
  always_comb begin
    ovf_d = ovf_q;
    if (stat_rd) ovf_d = 1'b0;
    if (ovf_evt) ovf_d = 1'b1;
  end

  always_comb begin
    o_data_d  = 32'h0;
    o_valid_d = 1'b0;
    if (data_rd) begin
      o_valid_d = 1'b1;
      if (pop) o_data_d = lane_word;
    end else if (stat_rd) begin
      o_valid_d = 1'b1;
      o_data_d  = status_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      o_data_q  <= 32'h0;
      o_valid_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign irq     = irq_w;

endmodule

// File: tb/tb_ctrl_merge.sv
// tb/tb_ctrl_merge.sv - directed self-checking bench for ctrl_merge
module tb_ctrl_merge;

  localparam logic [31:0] A_DATA = 32'h18;
  localparam logic [31:0] A_STAT = 32'h19;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_valid;
  logic [7:0]  p_data;
  logic        valid;
  logic [3:0]  ren;
  logic [31:0] addr;
  logic [31:0] o_data;
  logic        o_valid;
  logic        irq;

  int passes = 0;
  int total  = 0;

  ctrl_merge #(
    .DEPTH(8),
    .IRQ_TH(4),
    .ADDR_DATA(32'h18),
    .ADDR_STAT(32'h19)
  ) dut (
    .clk(clk),
    .rst(rst),
    .p_valid(p_valid),
    .p_data(p_data),
    .valid(valid),
    .ren(ren),
    .addr(addr),
    .o_data(o_data),
    .o_valid(o_valid),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input logic pv, input logic [7:0] pd, input logic v,
                      input logic [31:0] a, input logic [3:0] r);
    p_valid = pv; p_data = pd; valid = v; addr = a; ren = r;
    @(posedge clk); #1;
    p_valid = 1'b0; valid = 1'b0; addr = 32'h0; ren = 4'h0;
  endtask

  initial begin
    rst = 1'b1; p_valid = 1'b0; p_data = 8'h0; valid = 1'b0; ren = 4'h0; addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_o_data", o_data, 32'h0);
    chk("reset_o_valid", {31'h0, o_valid}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    step(0, 8'h00, 1, A_STAT, 4'h0);
    chk("reset_status", o_data, 32'h100);
    chk("reset_status_valid", {31'h0, o_valid}, 32'h1);

    step(1, 8'hA1, 0, 32'h0, 4'h0);
    step(1, 8'hB2, 0, 32'h0, 4'h0);
    step(1, 8'hC3, 0, 32'h0, 4'h0);
    chk("irq_at3", {31'h0, irq}, 32'h0);
    step(0, 8'h00, 1, A_DATA, 4'b0001);
    chk("rd_a1", o_data, 32'h0000_00A1);
    chk("rd_a1_valid", {31'h0, o_valid}, 32'h1);
    step(0, 8'h00, 1, A_DATA, 4'b0001);
    chk("rd_b2", o_data, 32'h0000_00B2);
    step(0, 8'h00, 1, A_DATA, 4'b0001);
    chk("rd_c3", o_data, 32'h0000_00C3);
    step(0, 8'h00, 0, 32'h0, 4'h0);
    chk("idle_o_valid", {31'h0, o_valid}, 32'h0);

    step(0, 8'h00, 1, A_DATA, 4'b0001);
    chk("empty_rd_data", o_data, 32'h0);
    chk("empty_rd_valid", {31'h0, o_valid}, 32'h1);
    step(0, 8'h00, 1, A_STAT, 4'h0);
    chk("empty_status", o_data, 32'h100);

    for (int i = 0; i < 9; i++) step(1, 8'h10 + 8'(i), 0, 32'h0, 4'h0);
    chk("irq_full", {31'h0, irq}, 32'h1);
    step(0, 8'h00, 1, A_STAT, 4'h0);
    chk("ovf_status", o_data, 32'hE08);
    step(0, 8'h00, 1, A_STAT, 4'h0);
    chk("ovf_cleared", o_data, 32'hA08);
    step(1, 8'h99, 1, A_STAT, 4'h0);
    chk("ovf_same_cycle_sample", o_data, 32'hA08);
    step(0, 8'h00, 1, A_STAT, 4'h0);
    chk("ovf_same_cycle_kept", o_data, 32'hE08);
    step(0, 8'h00, 1, A_STAT, 4'h0);
    chk("ovf_recleared", o_data, 32'hA08);

    step(1, 8'h5A, 1, A_DATA, 4'b0001);
    chk("full_pushpop_data", o_data, 32'h10);
    step(0, 8'h00, 1, A_STAT, 4'h0);
    chk("full_pushpop_status", o_data, 32'hA08);
    for (int i = 1; i < 8; i++) begin
      step(0, 8'h00, 1, A_DATA, 4'b0001);
      chk($sformatf("drain_%0d", i), o_data, 32'h10 + 32'(i));
    end
    step(0, 8'h00, 1, A_DATA, 4'b0001);
    chk("drain_5a_last", o_data, 32'h5A);
    step(0, 8'h00, 1, A_STAT, 4'h0);
    chk("drained_status", o_data, 32'h100);

    step(1, 8'h3C, 0, 32'h0, 4'h0);
    step(1, 8'h7E, 0, 32'h0, 4'h0);
    step(0, 8'h00, 1, A_DATA, 4'b0100);
    chk("lane2", o_data, 32'h003C_0000);
    step(0, 8'h00, 1, A_DATA, 4'b1010);
    chk("lane1_lowest", o_data, 32'h0000_7E00);
    step(1, 8'h11, 0, 32'h0, 4'h0);
    step(0, 8'h00, 1, A_DATA, 4'b0000);
    chk("ren0_data", o_data, 32'h0);
    chk("ren0_valid", {31'h0, o_valid}, 32'h1);
    step(0, 8'h00, 1, A_STAT, 4'h0);
    chk("ren0_no_pop", o_data, 32'h001);
    step(0, 8'h00, 1, A_DATA, 4'b1000);
    chk("lane3", o_data, 32'h1100_0000);
    step(0, 8'h00, 1, 32'h20, 4'b0001);
    chk("other_addr_valid", {31'h0, o_valid}, 32'h0);
    chk("other_addr_data", o_data, 32'h0);

    step(1, 8'h01, 0, 32'h0, 4'h0);
    step(1, 8'h02, 0, 32'h0, 4'h0);
    step(1, 8'h03, 0, 32'h0, 4'h0);
    chk("irq_push3", {31'h0, irq}, 32'h0);
    step(1, 8'h04, 0, 32'h0, 4'h0);
    chk("irq_push4", {31'h0, irq}, 32'h1);
    step(0, 8'h00, 1, A_STAT, 4'h0);
    chk("irq_status", o_data, 32'h804);
    step(0, 8'h00, 1, A_DATA, 4'b0001);
    chk("irq_pop_data", o_data, 32'h01);
    chk("irq_pop", {31'h0, irq}, 32'h0);

    step(1, 8'h05, 0, 32'h0, 4'h0);
    step(1, 8'h06, 0, 32'h0, 4'h0);
    step(0, 8'h00, 1, A_STAT, 4'h0);
    chk("pre_rst_status", o_data, 32'h805);
    p_valid = 1'b1; p_data = 8'h07;
    rst = 1'b1;
    #1;
    chk("rst_o_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_o_data", o_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; p_valid = 1'b0;
    step(0, 8'h00, 1, A_STAT, 4'h0);
    chk("post_rst_status", o_data, 32'h100);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
